// File: rtl/vproc_pkg.sv
// Shared widths and enumerations for the vector processor datapath blocks.
package vproc_pkg;

   localparam int ADDR_W = 9;
   localparam int LANES  = 16;
   localparam int WORD_W = 32;
   localparam int VEC_W  = LANES * WORD_W;
   localparam int LEN_W  = 3;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } lsu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_STORE
   } lsu_state_e;

endpackage

// File: rtl/vector_lsu_agen.sv
// Beat address generator: holds the running word address and beat count of the
// active command and flags the final beat.
module vector_lsu_agen
   import vproc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              last
);

   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_q;

   // The address wraps modulo the memory depth simply by overflowing ADDR_W bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr <= '0;
         cnt      <= '0;
         len_q    <= '0;
      end else if (load) begin
         cur_addr <= base;
         cnt      <= '0;
         len_q    <= len;
      end else if (advance) begin
         cur_addr <= cur_addr + ADDR_W'(LANES);
         cnt      <= cnt + LEN_W'(1);
      end
   end

   assign last = (cnt == len_q);

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer in front of the 512 x 32 vector data memory.
// Optional beat counters are enabled with `define VECTOR_LSU_PERF_EN.
module vector_lsu
   import vproc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [VEC_W-1:0]  wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [VEC_W-1:0]  rdata,
   output logic              rdata_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [VEC_W-1:0]  mem_wdata,
   input  logic [VEC_W-1:0]  mem_rdata,
   output logic              busy
`ifdef VECTOR_LSU_PERF_EN
   ,
   output logic [15:0]       perf_ld_beats,
   output logic [15:0]       perf_st_beats
`endif
);

   lsu_state_e        state_q, state_d;
   logic              ag_load, ag_advance, ag_last;
   logic              capture, st_beat;
   logic [ADDR_W-1:0] cur_addr;

   vector_lsu_agen u_agen (
      .clk      (clk),
      .reset    (reset),
      .load     (ag_load),
      .advance  (ag_advance),
      .base     (cmd_addr),
      .len      (cmd_len),
      .cur_addr (cur_addr),
      .last     (ag_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      ag_load     = 1'b0;
      ag_advance  = 1'b0;
      capture     = 1'b0;
      st_beat     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               ag_load = 1'b1;
               state_d = (lsu_op_e'(cmd_op) == OP_STORE) ? ST_STORE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            capture    = !rdata_valid || rdata_ready;
            ag_advance = capture;
            if (capture && ag_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rdata_valid && rdata_ready) state_d = ST_IDLE;
         end
         ST_STORE: begin
            wdata_ready = 1'b1;
            st_beat     = wdata_valid;
            ag_advance  = wdata_valid;
            if (wdata_valid && ag_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset gates the write strobe combinationally so an aborted store cannot land one more beat.
   assign mem_we    = st_beat && !reset;
   assign mem_addr  = cur_addr;
   assign mem_wdata = wdata;
   assign busy      = (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata       <= '0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
      end else if (capture) begin
         rdata       <= mem_rdata;
         rdata_valid <= 1'b1;
         rdata_last  <= ag_last;
      end else if (rdata_valid && rdata_ready) begin
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
      end
   end

`ifdef VECTOR_LSU_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_ld_beats <= '0;
         perf_st_beats <= '0;
      end else begin
         if (capture && perf_ld_beats != 16'hFFFF) perf_ld_beats <= perf_ld_beats + 16'd1;
         if (st_beat && perf_st_beats != 16'hFFFF) perf_st_beats <= perf_st_beats + 16'd1;
      end
   end
`endif

endmodule
